// File: rtl/sys_ctrl_fsm.sv
// Command-frame controller: decodes UART command frames into register-file and ALU
// operations and returns read data / ALU results byte-by-byte to the TX FIFO.
module sys_ctrl_fsm #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALU_OUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_DATA_VLD,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     TX_FIFO_FULL
);

  localparam logic [DATA_WIDTH-1:0] CmdWr     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CmdRd     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CmdAluOp  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CmdAluNop = DATA_WIDTH'(8'hDD);
  localparam logic [7:0]            TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StTxRd,
    StOpA, StOpB, StAluFun, StAluWait, StTxLsb, StTxMsb
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   res_msb_q, res_msb_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_vld;

  assign tx_vld = (state_q inside {StTxRd, StTxLsb, StTxMsb}) && !TX_FIFO_FULL;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    res_msb_d    = res_msb_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    tx_p_data_d  = tx_p_data_q;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CmdWr)          state_d = StWrAddr;
          else if (RX_P_DATA == CmdRd)     state_d = StRdAddr;
          else if (RX_P_DATA == CmdAluOp)  state_d = StOpA;
          else if (RX_P_DATA == CmdAluNop) state_d = StAluFun;
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = StWrData;
        end
      end
      StWrData: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = wr_addr_q;
          rf_wr_data_d = RX_P_DATA;
          state_d      = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          cnt_d      = '0;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving in the timeout cycle still wins.
        if (RF_RD_DATA_VLD) begin
          tx_p_data_d = RF_RD_DATA;
          state_d     = StTxRd;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
        end
      end
      StTxRd: begin
        if (tx_vld) state_d = StIdle;
      end
      StOpA, StOpB: begin
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = (state_q == StOpA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          rf_wr_data_d = RX_P_DATA;
          state_d      = (state_q == StOpA) ? StOpB : StAluFun;
        end
      end
      StAluFun: begin
        if (RX_D_VLD) begin
          alu_en_d  = 1'b1;
          alu_fun_d = RX_P_DATA[3:0];
          cnt_d     = '0;
          state_d   = StAluWait;
        end
      end
      StAluWait: begin
        cnt_d = cnt_q + 8'd1;
        if (ALU_OUT_VLD) begin
          tx_p_data_d = ALU_OUT[DATA_WIDTH-1:0];
          res_msb_d   = ALU_OUT[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
          state_d     = StTxLsb;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
        end
      end
      StTxLsb: begin
        if (tx_vld) begin
          tx_p_data_d = res_msb_q;
          state_d     = StTxMsb;
        end
      end
      StTxMsb: begin
        if (tx_vld) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    clk_gate_en_d = state_d inside {StAluFun, StAluWait};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wr_addr_q     <= '0;
      res_msb_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_addr_q     <= wr_addr_d;
      res_msb_q     <= res_msb_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_p_data_q   <= tx_p_data_d;
    end
  end

  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_vld;

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Bench for sys_ctrl_fsm: directed frame table, multi-cycle corner sequences and
// randomized frames checked against a transaction-level expectation model.
module tb_sys_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [3:0]  RF_ADDR, ALU_FUN;
  logic [7:0]  RF_WR_DATA, TX_P_DATA;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_FIFO_FULL = 1'b0;

  sys_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_FIFO_FULL(TX_FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // Responder settings, written only by the main sequence.
  logic        rsp_en = 1'b1;
  logic [15:0] rsp_val = '0;
  int          rsp_lat = 1;
  logic        rnd_full = 1'b0;

  // Register-file / ALU responder: pulses valid rsp_lat cycles after the strobe.
  int rd_cd = 0;
  int alu_cd = 0;
  always begin
    @(posedge CLK);
    #1;
    RF_RD_DATA_VLD = 1'b0;
    ALU_OUT_VLD    = 1'b0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin RF_RD_DATA = rsp_val[7:0]; RF_RD_DATA_VLD = 1'b1; end
    end
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin ALU_OUT = rsp_val; ALU_OUT_VLD = 1'b1; end
    end
    if (RF_RD_EN && rsp_en) rd_cd = rsp_lat;
    if (ALU_EN && rsp_en) alu_cd = rsp_lat;
  end

  // Observed events, sampled mid-cycle.
  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  int alu_en_cyc = 0, alu_vld_cyc = 0, rd_vld_cyc = 0, alu_vld_cnt = 0;
  int gate_rise_cyc = 0, gate_fall_cyc = 0;
  logic gate_prev = 1'b0;

  always @(negedge CLK) begin
    if (RF_WR_EN) wr_q.push_back({RF_ADDR, RF_WR_DATA});
    if (RF_RD_EN) rd_q.push_back(RF_ADDR);
    if (ALU_EN) begin alu_q.push_back(ALU_FUN); alu_en_cyc = cyc; end
    if (TX_D_VLD) begin tx_q.push_back(TX_P_DATA); tx_cyc_q.push_back(cyc); end
    if (ALU_OUT_VLD) begin alu_vld_cyc = cyc; alu_vld_cnt++; end
    if (RF_RD_DATA_VLD) rd_vld_cyc = cyc;
    if (CLK_GATE_EN && !gate_prev) gate_rise_cyc = cyc;
    if (!CLK_GATE_EN && gate_prev) gate_fall_cyc = cyc;
    gate_prev = CLK_GATE_EN;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rnd_full) TX_FIFO_FULL = ($urandom_range(0, 3) == 0);
  endtask

  // Bytes packed MSB-first in a 32-bit word; random idle gaps between them.
  task automatic send(input logic [31:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      RX_P_DATA = bytes[31-8*i -: 8];
      RX_D_VLD  = 1'b1;
      tick();
      RX_D_VLD  = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_tx(input int target, input int bound);
    int k = 0;
    while (tx_q.size() < target && k < bound) begin tick(); k++; end
  endtask

  typedef struct {
    logic [31:0] bytes; int nb;
    logic rsp; logic [15:0] rv; int lat;
    int nwr; logic [11:0] w0; logic [11:0] w1;
    int nrd; logic [3:0] ra;
    int nalu; logic [3:0] fn;
    int ntx; logic [7:0] t0; logic [7:0] t1;
  } vec_t;

  vec_t tab[7];
  vec_t v;
  int wb, rb, ab, tb, hold_bad, vc;
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_tx[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tab[0] = '{32'hAA053C00, 3, 1'b0, 16'h0,    1, 1, 12'h53C, 12'h0,  0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00};
    tab[1] = '{32'hBB070000, 2, 1'b1, 16'h005A, 3, 0, 12'h0,   12'h0,  1, 4'h7, 0, 4'h0, 1, 8'h5A, 8'h00};
    tab[2] = '{32'hCC123400, 4, 1'b1, 16'h0046, 2, 2, 12'h012, 12'h134, 0, 4'h0, 1, 4'h0, 2, 8'h46, 8'h00};
    tab[3] = '{32'hDD020000, 2, 1'b1, 16'hBEEF, 1, 0, 12'h0,   12'h0,  0, 4'h0, 1, 4'h2, 2, 8'hEF, 8'hBE};
    tab[4] = '{32'hAAF38100, 3, 1'b0, 16'h0,    1, 1, 12'h381, 12'h0,  0, 4'h0, 0, 4'h0, 0, 8'h00, 8'h00};
    tab[5] = '{32'hBB1C0000, 2, 1'b1, 16'h00A5, 1, 0, 12'h0,   12'h0,  1, 4'hC, 0, 4'h0, 1, 8'hA5, 8'h00};
    tab[6] = '{32'hDD1F0000, 2, 1'b1, 16'h1234, 5, 0, 12'h0,   12'h0,  0, 4'h0, 1, 4'hF, 2, 8'h34, 8'h12};

    repeat (3) tick();
    chk("reset_outputs", {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
                          CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'h0);
    RST = 1'b1;
    tick();

    // Directed frame table.
    for (int i = 0; i < 7; i++) begin
      v = tab[i];
      wb = wr_q.size(); rb = rd_q.size(); ab = alu_q.size(); tb = tx_q.size();
      rsp_en = v.rsp; rsp_val = v.rv; rsp_lat = v.lat;
      send(v.bytes, v.nb);
      wait_tx(tb + v.ntx, 400);
      repeat (4) tick();
      chk($sformatf("v%0d_nwr", i), wr_q.size() - wb, v.nwr);
      chk($sformatf("v%0d_nrd", i), rd_q.size() - rb, v.nrd);
      chk($sformatf("v%0d_nalu", i), alu_q.size() - ab, v.nalu);
      chk($sformatf("v%0d_ntx", i), tx_q.size() - tb, v.ntx);
      if (v.nwr > 0 && wr_q.size() > wb) chk($sformatf("v%0d_wr0", i), wr_q[wb], v.w0);
      if (v.nwr > 1 && wr_q.size() > wb + 1) chk($sformatf("v%0d_wr1", i), wr_q[wb+1], v.w1);
      if (v.nrd > 0 && rd_q.size() > rb) chk($sformatf("v%0d_rd", i), rd_q[rb], v.ra);
      if (v.nalu > 0 && alu_q.size() > ab) begin
        chk($sformatf("v%0d_fun", i), alu_q[ab], v.fn);
        chk($sformatf("v%0d_gate_before_en", i), gate_rise_cyc < alu_en_cyc, 1);
        chk($sformatf("v%0d_gate_drop", i), gate_fall_cyc, alu_vld_cyc + 1);
      end
      if (v.ntx > 0 && tx_q.size() > tb) begin
        chk($sformatf("v%0d_tx0", i), tx_q[tb], v.t0);
        chk($sformatf("v%0d_tx0_lat", i), tx_cyc_q[tb],
            (v.nalu > 0 ? alu_vld_cyc : rd_vld_cyc) + 1);
      end
      if (v.ntx > 1 && tx_q.size() > tb + 1) begin
        chk($sformatf("v%0d_tx1", i), tx_q[tb+1], v.t1);
        chk($sformatf("v%0d_tx_consec", i), tx_cyc_q[tb+1], tx_cyc_q[tb] + 1);
      end
    end

    // FIFO full for 10 cycles after the ALU result.
    tb = tx_q.size(); vc = alu_vld_cnt; hold_bad = 0;
    rsp_en = 1'b1; rsp_val = 16'hC3A1; rsp_lat = 2;
    TX_FIFO_FULL = 1'b1;
    send(32'hDD020000, 2);
    for (int k = 0; k < 100 && alu_vld_cnt == vc; k++) tick();
    for (int k = 0; k < 10; k++) begin
      if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'hA1) hold_bad++;
      tick();
    end
    chk("full_hold", hold_bad, 0);
    chk("full_no_tx", tx_q.size() - tb, 0);
    TX_FIFO_FULL = 1'b0;
    wait_tx(tb + 2, 50);
    chk("full_ntx", tx_q.size() - tb, 2);
    if (tx_q.size() >= tb + 2) begin
      chk("full_lsb", tx_q[tb], 8'hA1);
      chk("full_msb", tx_q[tb+1], 8'hC3);
      chk("full_consec", tx_cyc_q[tb+1], tx_cyc_q[tb] + 1);
    end

    // Unknown command, then a read that never answers; bytes during the wait are dropped.
    wb = wr_q.size(); rb = rd_q.size(); tb = tx_q.size();
    rsp_en = 1'b0;
    send(32'h77000000, 1);
    send(32'hBB030000, 2);
    repeat (200) tick();
    send(32'hAA091100, 3);
    repeat (80) tick();
    send(32'hAA0A2200, 3);
    repeat (4) tick();
    chk("unk_rd_addr", (rd_q.size() > rb) ? rd_q[rb] : 4'hX, 4'h3);
    chk("tmo_nwr", wr_q.size() - wb, 1);
    chk("tmo_wr", (wr_q.size() > wb) ? wr_q[wb] : 12'hXXX, 12'hA22);
    chk("tmo_ntx", tx_q.size() - tb, 0);

    // Response arriving exactly in the timeout cycle still wins.
    tb = tx_q.size();
    rsp_en = 1'b1; rsp_val = 16'h006E; rsp_lat = 255;
    send(32'hBB040000, 2);
    wait_tx(tb + 1, 400);
    chk("vld_wins_ntx", tx_q.size() - tb, 1);
    chk("vld_wins_data", (tx_q.size() > tb) ? tx_q[tb] : 8'hXX, 8'h6E);

    // ALU timeout: clock gate released about TIMEOUT_CYCLES after ALU_EN, no TX.
    tb = tx_q.size();
    rsp_en = 1'b0;
    send(32'hDD030000, 2);
    repeat (300) tick();
    chk("alu_tmo_gate", (gate_fall_cyc - alu_en_cyc >= 255) && (gate_fall_cyc - alu_en_cyc <= 257), 1);
    chk("alu_tmo_ntx", tx_q.size() - tb, 0);
    chk("alu_tmo_gate_low", CLK_GATE_EN, 1'b0);

    // Reset between the opA and opB bytes.
    rsp_en = 1'b1;
    send(32'hCC120000, 2);
    RST = 1'b0;
    #1;
    chk("midrst_outputs", {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
                           CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'h0);
    tick(); tick();
    RST = 1'b1;
    tick();
    wb = wr_q.size(); ab = alu_q.size();
    send(32'hAA01FF00, 3);
    repeat (6) tick();
    chk("midrst_nwr", wr_q.size() - wb, 1);
    chk("midrst_wr", (wr_q.size() > wb) ? wr_q[wb] : 12'hXXX, 12'h1FF);
    chk("midrst_nalu", alu_q.size() - ab, 0);

    // Randomized frames against a transaction-level model.
    wb = wr_q.size(); rb = rd_q.size(); ab = alu_q.size(); tb = tx_q.size();
    rnd_full = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind;
      logic [7:0] a, b, c;
      kind = $urandom_range(0, 4);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      rsp_en = ($urandom_range(0, 7) != 0);
      rsp_val = 16'($urandom);
      rsp_lat = $urandom_range(1, 20);
      case (kind)
        0: begin
          send({8'hAA, a, b, 8'h00}, 3);
          exp_wr.push_back({a[3:0], b});
        end
        1: begin
          send({8'hBB, a, 16'h0}, 2);
          exp_rd.push_back(a[3:0]);
          if (rsp_en) exp_tx.push_back(rsp_val[7:0]);
        end
        2: begin
          send({8'hCC, a, b, c}, 4);
          exp_wr.push_back({4'h0, a});
          exp_wr.push_back({4'h1, b});
          exp_alu.push_back(c[3:0]);
          if (rsp_en) begin exp_tx.push_back(rsp_val[7:0]); exp_tx.push_back(rsp_val[15:8]); end
        end
        3: begin
          send({8'hDD, c, 16'h0}, 2);
          exp_alu.push_back(c[3:0]);
          if (rsp_en) begin exp_tx.push_back(rsp_val[7:0]); exp_tx.push_back(rsp_val[15:8]); end
        end
        default: begin
          while (a inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) a = 8'($urandom);
          send({a, 24'h0}, 1);
        end
      endcase
      if (!rsp_en && kind inside {1, 2, 3}) repeat (270) tick();
      wait_tx(tb + exp_tx.size(), 400);
      repeat (3) tick();
    end
    rnd_full = 1'b0;
    TX_FIFO_FULL = 1'b0;
    repeat (5) tick();

    chk("rnd_nwr", wr_q.size() - wb, exp_wr.size());
    chk("rnd_nrd", rd_q.size() - rb, exp_rd.size());
    chk("rnd_nalu", alu_q.size() - ab, exp_alu.size());
    chk("rnd_ntx", tx_q.size() - tb, exp_tx.size());
    for (int i = 0; i < exp_wr.size() && wb + i < wr_q.size(); i++)
      chk($sformatf("rnd_wr%0d", i), wr_q[wb+i], exp_wr[i]);
    for (int i = 0; i < exp_rd.size() && rb + i < rd_q.size(); i++)
      chk($sformatf("rnd_rd%0d", i), rd_q[rb+i], exp_rd[i]);
    for (int i = 0; i < exp_alu.size() && ab + i < alu_q.size(); i++)
      chk($sformatf("rnd_alu%0d", i), alu_q[ab+i], exp_alu[i]);
    for (int i = 0; i < exp_tx.size() && tb + i < tx_q.size(); i++)
      chk($sformatf("rnd_tx%0d", i), tx_q[tb+i], exp_tx[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_fsm.md
# sys_ctrl_fsm

Command-frame controller between the UART receive path and the register-file/ALU datapath. It consumes byte-wide command frames, sequences register-file writes and reads, and drives ALU operations together with their clock gate. It returns read data and ALU results byte-by-byte to the TX FIFO under full-flag backpressure. It is the only master of the register file and ALU in the reference clock domain.

## Interface
- DATA_WIDTH, 8, byte width of frames, register file and TX path
- ADDR_WIDTH, 4, register-file address width
- ALU_OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH
- TIMEOUT_CYCLES, 255, maximum cycles to wait for a read or ALU response
- CLK  in  1  single clock; every flop is on the rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  single-cycle pulse; RX_P_DATA is valid
- RF_WR_EN / RF_RD_EN  out  1 each  register-file write / read strobes
- RF_ADDR  out  ADDR_WIDTH  register-file address
- RF_WR_DATA  out  DATA_WIDTH  register-file write data
- RF_RD_DATA  in  DATA_WIDTH  read data
- RF_RD_DATA_VLD  in  1  read data valid pulse
- ALU_EN  out  1  single-cycle ALU start
- ALU_FUN  out  4  ALU function code
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_VLD  in  1  result valid pulse
- CLK_GATE_EN  out  1  enables the ALU clock gate
- TX_P_DATA  out  DATA_WIDTH  byte to the TX FIFO
- TX_D_VLD  out  1  TX FIFO write strobe
- TX_FIFO_FULL  in  1  TX FIFO full

## Operation
- Frame formats, first byte = command:
  - 0xAA write: addr, data. No response.
  - 0xBB read: addr. Response: 1 byte.
  - 0xCC ALU with operands: opA, opB, fun. opA is written to RF address 0 and opB to address 1. Response: 2 bytes, LSB first.
  - 0xDD ALU without operands: fun. Response: 2 bytes, LSB first.
  - Any other command byte is discarded and the FSM stays in IDLE.
- States:
  - IDLE → WR_ADDR (0xAA), RD_ADDR (0xBB), OPA (0xCC), ALU_FUN (0xDD) on RX_D_VLD.
  - WR_ADDR → WR_DATA → IDLE.
  - RD_ADDR → RD_WAIT → TX_RD → IDLE.
  - OPA → OPB → ALU_FUN → ALU_WAIT → TX_LSB → TX_MSB → IDLE.
- Transitions out of the frame-receiving states (WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN) occur only on RX_D_VLD.
- Addresses use RX_P_DATA[ADDR_WIDTH-1:0]; upper bits are ignored. ALU_FUN uses RX_P_DATA[3:0].
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state is ignored and the byte is dropped.
- Response capture:
  - RD_WAIT latches RF_RD_DATA on RF_RD_DATA_VLD.
  - ALU_WAIT latches ALU_OUT on ALU_OUT_VLD.
- Timeout: an 8-bit counter clears on entry to RD_WAIT or ALU_WAIT and increments each cycle. When it reaches TIMEOUT_CYCLES with no valid pulse, the FSM returns to IDLE and sends no TX bytes.
- If a valid pulse and the timeout occur in the same cycle, the valid pulse wins.
- RF_ADDR, RF_WR_DATA, ALU_FUN and TX_P_DATA hold their last values when not strobed.

## Timing
- Reset: every output is 0 and the state is IDLE. Reset asserted mid-frame aborts the frame with no strobe or TX write.
- Strobes are registered and are exactly one cycle wide:
  - RF_WR_EN is high the cycle after the RX_D_VLD of the data byte, opA byte or opB byte, with RF_ADDR and RF_WR_DATA valid in that same cycle.
  - RF_RD_EN is high the cycle after the addr byte's RX_D_VLD.
  - ALU_EN is high the cycle after the fun byte's RX_D_VLD, with ALU_FUN valid.
- CLK_GATE_EN is registered. It is high in every cycle the state is ALU_FUN or ALU_WAIT, so it precedes ALU_EN by at least one cycle. It drops the cycle after the result is captured or the timeout fires.
- TX_D_VLD is combinational: (state ∈ {TX_RD, TX_LSB, TX_MSB}) & !TX_FIFO_FULL.
  - TX_P_DATA is registered and stable throughout the TX state.
  - The state advances only in a cycle where TX_D_VLD=1; a full FIFO holds the state indefinitely.
- Minimum latency from the last response-valid pulse to the first TX_D_VLD is 1 cycle. The two ALU bytes are sent on consecutive cycles when the FIFO is not full.
- A new frame's command byte is accepted the cycle after returning to IDLE.

## Test plan
- Write frame AA,05,3C → one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C; TX_D_VLD stays 0.
- Read frame BB,07; RF_RD_DATA=0x5A returned 3 cycles after RF_RD_EN → exactly one TX write of 0x5A, then IDLE.
- Frame CC,12,34,00 with ALU_OUT=0x0046 → writes addr0=0x12 and addr1=0x34; CLK_GATE_EN rises before ALU_EN with ALU_FUN=0; TX writes 0x46 then 0x00.
- Frame DD,02 with TX_FIFO_FULL=1 for 10 cycles after the result → TX_D_VLD stays 0 and the state holds; after full deasserts, two consecutive writes of LSB then MSB.
- Unknown byte 0x77, then read BB,03 with no RF_RD_DATA_VLD → 0x77 is ignored; the timeout returns the FSM to IDLE after 255 cycles with no TX write.
- RST asserted between OPA and OPB bytes → all outputs 0 and state IDLE; the following frame AA,01,FF completes normally.
